// File: rtl/ex_redirect_unit.sv
// ex_redirect_unit: execute-stage branch/jump resolution and front-end redirect sequencer.
//
// Resolves conditional branches, jal and jalr for the instruction in the ID/EX
// slot. A taken instruction produces a one-cycle PCsel strobe with its target on
// JumporBranch. Flush is then held for three cycles (REDIRECT, FLUSH1, FLUSH2).
// Instructions that arrive while a redirect is in flight are squashed.
//
// Ports:
//   CLK, RSTB              clock (rising edge), asynchronous active-low reset
//   CNTEN                  advance enable; 0 freezes every register
//   InValid                ID/EX slot holds a live instruction
//   PC, rs1val, rs2val     instruction PC and source operands
//   LoadStoreOrjalAddress  sign-extended, pre-shifted offset
//   IsBranch/IsJal/IsJalr  instruction class (priority jalr > jal > branch)
//   BrType                 funct3 branch condition
//   PCsel, JumporBranch    redirect strobe and target to IF/ID
//   Flush                  squash IF/ID and ID/EX
//   LinkValid, LinkData    pending rd write of PC+4 for jal/jalr
//   RedirectCount          saturating count of taken redirects
//
// Build option: define BRANCH_STATS_EN to enable RedirectCount; otherwise it is
// tied to zero.

module ex_redirect_unit (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        CNTEN,
  input  logic        InValid,
  input  logic [31:0] PC,
  input  logic [31:0] rs1val,
  input  logic [31:0] rs2val,
  input  logic [31:0] LoadStoreOrjalAddress,
  input  logic        IsBranch,
  input  logic        IsJal,
  input  logic        IsJalr,
  input  logic [2:0]  BrType,
  output logic        PCsel,
  output logic [31:0] JumporBranch,
  output logic        Flush,
  output logic        LinkValid,
  output logic [31:0] LinkData,
  output logic [15:0] RedirectCount
);

  typedef enum logic [1:0] {StIdle, StRedirect, StFlush1, StFlush2} state_e;

  state_e      state_q;
  logic        pcsel_q;
  logic        flush_q;
  logic        link_valid_q;
  logic [31:0] target_q;
  logic [31:0] link_data_q;

  logic        cond;
  logic        is_link;
  logic        taken;
  logic [31:0] pc_sum;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic [31:0] link_pc;
  logic        redirect_entry;

  // Branch condition decode; 010/011 are reserved and never taken.
  always_comb begin
    cond = 1'b0;
    case (BrType)
      3'b000:  cond = (rs1val == rs2val);
      3'b001:  cond = (rs1val != rs2val);
      3'b100:  cond = ($signed(rs1val) <  $signed(rs2val));
      3'b101:  cond = ($signed(rs1val) >= $signed(rs2val));
      3'b110:  cond = (rs1val <  rs2val);
      3'b111:  cond = (rs1val >= rs2val);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_sum   = PC + LoadStoreOrjalAddress;
    jalr_sum = rs1val + LoadStoreOrjalAddress;
    link_pc  = PC + 32'd4;
    is_link  = IsJalr | IsJal;
    taken    = is_link | (IsBranch & cond);
    // jalr outranks jal and branch, so it alone selects the register-based target.
    target   = IsJalr ? (jalr_sum & ~32'd1) : pc_sum;
  end

  assign redirect_entry = CNTEN && (state_q == StIdle) && InValid && taken;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= StIdle;
      pcsel_q      <= 1'b0;
      flush_q      <= 1'b0;
      link_valid_q <= 1'b0;
      target_q     <= '0;
      link_data_q  <= '0;
    end else if (CNTEN) begin
      // Link strobe lasts one sampled cycle unless re-armed below.
      link_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (InValid && taken) begin
            state_q  <= StRedirect;
            pcsel_q  <= 1'b1;
            flush_q  <= 1'b1;
            target_q <= target;
            if (is_link) begin
              link_valid_q <= 1'b1;
              link_data_q  <= link_pc;
            end
          end else begin
            pcsel_q <= 1'b0;
            flush_q <= 1'b0;
          end
        end
        // Any InValid seen in the remaining states is squashed by not looking at it.
        StRedirect: begin
          state_q <= StFlush1;
          pcsel_q <= 1'b0;
          flush_q <= 1'b1;
        end
        StFlush1: begin
          state_q <= StFlush2;
          pcsel_q <= 1'b0;
          flush_q <= 1'b1;
        end
        StFlush2: begin
          state_q <= StIdle;
          pcsel_q <= 1'b0;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          pcsel_q <= 1'b0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      count_q <= '0;
    end else if (redirect_entry && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign RedirectCount = count_q;
`else
  logic unused_entry;
  assign unused_entry  = redirect_entry;
  assign RedirectCount = '0;
`endif

  assign PCsel        = pcsel_q;
  assign Flush        = flush_q;
  assign LinkValid    = link_valid_q;
  assign LinkData     = link_data_q;
  assign JumporBranch = target_q;

endmodule

// File: tb/tb_ex_redirect_unit.sv
module tb_ex_redirect_unit;

  logic        CLK;
  logic        RSTB;
  logic        CNTEN;
  logic        InValid;
  logic [31:0] PC;
  logic [31:0] rs1val;
  logic [31:0] rs2val;
  logic [31:0] LoadStoreOrjalAddress;
  logic        IsBranch;
  logic        IsJal;
  logic        IsJalr;
  logic [2:0]  BrType;
  logic        PCsel;
  logic [31:0] JumporBranch;
  logic        Flush;
  logic        LinkValid;
  logic [31:0] LinkData;
  logic [15:0] RedirectCount;

  int n_tests = 0;
  int n_fail  = 0;

  ex_redirect_unit dut (
    .CLK                  (CLK),
    .RSTB                 (RSTB),
    .CNTEN                (CNTEN),
    .InValid              (InValid),
    .PC                   (PC),
    .rs1val               (rs1val),
    .rs2val               (rs2val),
    .LoadStoreOrjalAddress(LoadStoreOrjalAddress),
    .IsBranch             (IsBranch),
    .IsJal                (IsJal),
    .IsJalr               (IsJalr),
    .BrType               (BrType),
    .PCsel                (PCsel),
    .JumporBranch         (JumporBranch),
    .Flush                (Flush),
    .LinkValid            (LinkValid),
    .LinkData             (LinkData),
    .RedirectCount        (RedirectCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] off, input logic br, input logic jal,
                       input logic jalr, input logic [2:0] bt);
    InValid               = 1'b1;
    PC                    = pc;
    rs1val                = a;
    rs2val                = b;
    LoadStoreOrjalAddress = off;
    IsBranch              = br;
    IsJal                 = jal;
    IsJalr                = jalr;
    BrType                = bt;
  endtask

  task automatic idle_in();
    InValid  = 1'b0;
    IsBranch = 1'b0;
    IsJal    = 1'b0;
    IsJalr   = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTB  = 1'b0;
    CNTEN = 1'b1;
    PC = '0; rs1val = '0; rs2val = '0; LoadStoreOrjalAddress = '0; BrType = '0;
    idle_in();
    #12;
    n_tests++;
    if ({PCsel, Flush, LinkValid} !== 3'b000 || JumporBranch !== 32'h0 ||
        LinkData !== 32'h0 || RedirectCount !== 16'h0) begin
      $display("FAIL reset_outputs: got pcsel=%0b flush=%0b lv=%0b jb=%h ld=%h cnt=%h want all 0",
               PCsel, Flush, LinkValid, JumporBranch, LinkData, RedirectCount);
      n_fail++;
    end
    #5 RSTB = 1'b1;
  endtask

  task automatic test_beq();
    drive(32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 1'b0, 1'b0, 3'b000);
    step();
    idle_in();
    n_tests++;
    if (PCsel !== 1'b1 || Flush !== 1'b1 || JumporBranch !== 32'h120 || LinkValid !== 1'b0) begin
      $display("FAIL beq_redirect: got pcsel=%0b flush=%0b jb=%h lv=%0b want 1 1 00000120 0",
               PCsel, Flush, JumporBranch, LinkValid);
      n_fail++;
    end
    step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b1) begin
      $display("FAIL beq_flush1: got pcsel=%0b flush=%0b want 0 1", PCsel, Flush);
      n_fail++;
    end
    step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b1) begin
      $display("FAIL beq_flush2: got pcsel=%0b flush=%0b want 0 1", PCsel, Flush);
      n_fail++;
    end
    step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b0 || JumporBranch !== 32'h120) begin
      $display("FAIL beq_done: got pcsel=%0b flush=%0b jb=%h want 0 0 00000120",
               PCsel, Flush, JumporBranch);
      n_fail++;
    end
  endtask

  task automatic test_blt_bltu();
    drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b100);
    step();
    idle_in();
    n_tests++;
    if (PCsel !== 1'b1 || JumporBranch !== 32'h208) begin
      $display("FAIL blt_taken: got pcsel=%0b jb=%h want 1 00000208", PCsel, JumporBranch);
      n_fail++;
    end
    step(); step(); step();
    drive(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b110);
    step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b0 || JumporBranch !== 32'h208) begin
      $display("FAIL bltu_not_taken: got pcsel=%0b flush=%0b jb=%h want 0 0 00000208",
               PCsel, Flush, JumporBranch);
      n_fail++;
    end
    // Reserved funct3 never takes, even with equal operands.
    drive(32'h300, 32'd7, 32'd7, 32'h8, 1'b1, 1'b0, 1'b0, 3'b010);
    step();
    n_tests++;
    if (PCsel !== 1'b0) begin
      $display("FAIL br010_not_taken: got pcsel=%0b want 0", PCsel);
      n_fail++;
    end
    // BGE signed: -1 >= 1 is false.
    drive(32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b101);
    step();
    idle_in();
    n_tests++;
    if (PCsel !== 1'b0) begin
      $display("FAIL bge_not_taken: got pcsel=%0b want 0", PCsel);
      n_fail++;
    end
  endtask

  task automatic test_jalr();
    drive(32'h400, 32'h203, 32'h0, 32'h10, 1'b0, 1'b0, 1'b1, 3'b000);
    step();
    idle_in();
    n_tests++;
    if (PCsel !== 1'b1 || JumporBranch !== 32'h212 || LinkValid !== 1'b1 ||
        LinkData !== 32'h404) begin
      $display("FAIL jalr: got pcsel=%0b jb=%h lv=%0b ld=%h want 1 00000212 1 00000404",
               PCsel, JumporBranch, LinkValid, LinkData);
      n_fail++;
    end
    step();
    n_tests++;
    if (LinkValid !== 1'b0) begin
      $display("FAIL jalr_link_one_cycle: got lv=%0b want 0", LinkValid);
      n_fail++;
    end
    step(); step();
  endtask

  task automatic test_wrap();
    drive(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 1'b0, 1'b1, 1'b0, 3'b000);
    step();
    idle_in();
    n_tests++;
    if (JumporBranch !== 32'h4 || LinkData !== 32'h0 || LinkValid !== 1'b1 || PCsel !== 1'b1) begin
      $display("FAIL jal_wrap: got jb=%h ld=%h lv=%0b pcsel=%0b want 00000004 00000000 1 1",
               JumporBranch, LinkData, LinkValid, PCsel);
      n_fail++;
    end
    step(); step(); step();
  endtask

  task automatic test_priority();
    // All three class bits set: jalr wins, target from rs1.
    drive(32'h1000, 32'h51, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1, 3'b000);
    step();
    idle_in();
    n_tests++;
    if (JumporBranch !== 32'h54 || LinkData !== 32'h1004) begin
      $display("FAIL priority_jalr: got jb=%h ld=%h want 00000054 00001004",
               JumporBranch, LinkData);
      n_fail++;
    end
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    drive(32'h200, 32'd3, 32'd3, 32'h40, 1'b1, 1'b0, 1'b0, 3'b000);
    step();
    pulses = int'(PCsel);
    drive(32'h300, 32'd3, 32'd3, 32'h10, 1'b1, 1'b0, 1'b0, 3'b000);
    step();
    idle_in();
    pulses += int'(PCsel);
    n_tests++;
    if (JumporBranch !== 32'h240) begin
      $display("FAIL b2b_squash_target: got jb=%h want 00000240", JumporBranch);
      n_fail++;
    end
    step(); pulses += int'(PCsel);
    step(); pulses += int'(PCsel);
    n_tests++;
    if (pulses != 1 || Flush !== 1'b0) begin
      $display("FAIL b2b_single_pulse: got pulses=%0d flush=%0b want 1 0", pulses, Flush);
      n_fail++;
    end
    // Freeze while in REDIRECT.
    drive(32'h500, 32'd1, 32'd2, 32'h20, 1'b1, 1'b0, 1'b0, 3'b001);
    step();
    idle_in();
    CNTEN = 1'b0;
    step(); step(); step();
    n_tests++;
    if (PCsel !== 1'b1 || Flush !== 1'b1 || JumporBranch !== 32'h520) begin
      $display("FAIL cnten_hold: got pcsel=%0b flush=%0b jb=%h want 1 1 00000520",
               PCsel, Flush, JumporBranch);
      n_fail++;
    end
    CNTEN = 1'b1;
    step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b1) begin
      $display("FAIL cnten_resume: got pcsel=%0b flush=%0b want 0 1", PCsel, Flush);
      n_fail++;
    end
    step(); step();
  endtask

  task automatic test_reset_mid();
    drive(32'h600, 32'd9, 32'd9, 32'h30, 1'b1, 1'b0, 1'b0, 3'b000);
    step();
    idle_in();
    step();
    // Now in FLUSH1.
    #2 RSTB = 1'b0;
    #1;
    n_tests++;
    if ({PCsel, Flush, LinkValid} !== 3'b000 || JumporBranch !== 32'h0 ||
        LinkData !== 32'h0 || RedirectCount !== 16'h0) begin
      $display("FAIL reset_mid_flush: got pcsel=%0b flush=%0b lv=%0b jb=%h ld=%h cnt=%h want all 0",
               PCsel, Flush, LinkValid, JumporBranch, LinkData, RedirectCount);
      n_fail++;
    end
    #2 RSTB = 1'b1;
    step(); step();
    n_tests++;
    if (PCsel !== 1'b0 || Flush !== 1'b0) begin
      $display("FAIL reset_no_residual: got pcsel=%0b flush=%0b want 0 0", PCsel, Flush);
      n_fail++;
    end
    // Release then immediately present a jal on the first sampled edge.
    RSTB = 1'b0;
    #2 RSTB = 1'b1;
    drive(32'h700, 32'h0, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, 3'b000);
    step();
    idle_in();
    n_tests++;
    if (PCsel !== 1'b1 || JumporBranch !== 32'h800 || LinkData !== 32'h704) begin
      $display("FAIL first_edge_after_reset: got pcsel=%0b jb=%h ld=%h want 1 00000800 00000704",
               PCsel, JumporBranch, LinkData);
      n_fail++;
    end
    step(); step(); step();
    for (int i = 0; i < 2; i++) begin
      drive(32'h900, 32'd4, 32'd4, 32'h4, 1'b1, 1'b0, 1'b0, 3'b000);
      step();
      idle_in();
      step(); step(); step();
    end
    n_tests++;
`ifdef BRANCH_STATS_EN
    if (RedirectCount !== 16'd3) begin
      $display("FAIL redirect_count: got %0d want 3", RedirectCount);
      n_fail++;
    end
`else
    if (RedirectCount !== 16'd0) begin
      $display("FAIL redirect_count: got %0d want 0", RedirectCount);
      n_fail++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_jalr();
    test_wrap();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
